// File: rtl/shifter_pkg.sv
// Shared types for the iterative shifter.
// Mode and FSM encodings used by the top level and the step shifter.
package shifter_pkg;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/iterative_shifter_step.sv
// Combinational shifter moving data by 0..STEP places.
// Rotate support only when SHIFTER_ROTATE_EN is defined.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int AW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] d,
  input  logic [AW-1:0]    amt,
  input  shift_mode_e      mode,
  output logic [WIDTH-1:0] q
);

`ifdef SHIFTER_ROTATE_EN
  logic [2*WIDTH-1:0] rot;
  assign rot = {d, d} >> amt;
`endif

  always_comb begin
    q = d;
    unique case (mode)
      SHIFT_SLL: q = d << amt;
      SHIFT_SRL: q = d >> amt;
      SHIFT_SRA: q = $signed(d) >>> amt;
`ifdef SHIFTER_ROTATE_EN
      SHIFT_ROR: q = rot[WIDTH-1:0];
`else
      default:   q = d;
`endif
    endcase
  end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle SLL/SRL/SRA shifter, STEP bits per cycle.
// Define SHIFTER_ROTATE_EN to enable mode 11 rotate-right.
module iterative_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int STEP    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
);

  localparam int AW = $clog2(STEP + 1);
  localparam logic [AW-1:0] STEP_A = AW'(STEP);
  localparam logic [SHAMT_W:0] STEP_E = (SHAMT_W + 1)'(STEP);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  shift_mode_e        mode_q, mode_d;
  logic [AW-1:0]      k;
  logic [WIDTH-1:0]   step_q;

  // Clamp the per-cycle amount to STEP; the last step takes the remainder.
  always_comb begin
    k = STEP_A;
    if ({1'b0, rem_q} <= STEP_E) k = AW'(rem_q);
  end

  shift_step #(
    .WIDTH(WIDTH),
    .STEP (STEP),
    .AW   (AW)
  ) u_step (
    .d   (data_q),
    .amt (k),
    .mode(mode_q),
    .q   (step_q)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d = in_data;
          mode_d = shift_mode_e'(in_mode);
          rem_d  = in_shamt;
`ifndef SHIFTER_ROTATE_EN
          if (shift_mode_e'(in_mode) == SHIFT_ROR) rem_d = '0;
`endif
          state_d = (rem_d != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        data_d = step_q;
        rem_d  = rem_q - SHAMT_W'(k);
        if (rem_d == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      mode_q  <= SHIFT_SLL;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = data_q;

endmodule

// File: tb/tb_iterative_shifter.sv
// Directed-vector bench for iterative_shifter, WIDTH=32, STEP=4.
// Covers SLL/SRL/SRA, latency, backpressure, reset abort, mode 11.
module tb_iterative_shifter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int checks;
  int failures;

  iterative_shifter #(
    .WIDTH(32),
    .STEP (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_shamt (in_shamt),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge
  // where out_valid is first seen, with the cycle count since accept.
  task automatic run_op(input logic [31:0] d, input logic [4:0] s,
                        input logic [1:0] m, output int lat,
                        output logic [31:0] r);
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = s;
    in_mode  = m;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 32'hA5A5_A5A5;
    in_shamt = 5'd17;
    in_mode  = 2'b00;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    r = out_data;
  endtask

  int          lat;
  logic [31:0] res;
  int          acc;
  int          outs;

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_mode   = '0;
    out_ready = 1'b1;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(32'h1, 5'd2, 2'b00, lat, res);
    chk("sll2_data", res, 32'h4);
    chk("sll2_lat", 32'(lat), 32'd2);
    chk("sll2_busy", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("sll2_ready3", 32'(in_ready), 32'd1);

    run_op(32'h8000_0000, 5'd31, 2'b10, lat, res);
    chk("sra31_data", res, 32'hFFFF_FFFF);
    chk("sra31_lat", 32'(lat), 32'd9);
    @(negedge clk);
    run_op(32'h8000_0000, 5'd31, 2'b01, lat, res);
    chk("srl31_data", res, 32'h1);
    chk("srl31_lat", 32'(lat), 32'd9);
    @(negedge clk);

    run_op(32'hF000_0000, 5'd0, 2'b01, lat, res);
    chk("srl0_data", res, 32'hF000_0000);
    chk("srl0_lat", 32'(lat), 32'd1);
    @(negedge clk);

    run_op(32'h1234_5678, 5'd4, 2'b00, lat, res);
    chk("sll4_data", res, 32'h2345_6780);
    chk("sll4_lat", 32'(lat), 32'd2);
    @(negedge clk);
    run_op(32'h7000_0000, 5'd5, 2'b10, lat, res);
    chk("sra5_data", res, 32'h0380_0000);
    chk("sra5_lat", 32'(lat), 32'd3);
    @(negedge clk);
    run_op(32'h8000_0000, 5'd9, 2'b01, lat, res);
    chk("srl9_data", res, 32'h0040_0000);
    chk("srl9_lat", 32'(lat), 32'd4);
    @(negedge clk);

    // Back-to-back zero-shift operands with out_ready held high.
    acc      = 0;
    outs     = 0;
    in_valid = 1'b1;
    in_data  = 32'h0000_0F0F;
    in_shamt = 5'd0;
    in_mode  = 2'b01;
    for (int i = 0; i < 10; i++) begin
      if (in_ready) acc++;
      if (out_valid) outs++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("b2b_accepts", 32'(acc), 32'd5);
    chk("b2b_results", 32'(outs), 32'd5);
    while (!in_ready) @(negedge clk);

    // Backpressure: result must hold and new operands be ignored.
    out_ready = 1'b0;
    run_op(32'hFF, 5'd8, 2'b00, lat, res);
    chk("bp_data", res, 32'h0000_FF00);
    chk("bp_lat", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_data  = 32'hDEAD_BEEF;
      in_shamt = 5'd3;
      @(negedge clk);
      chk("bp_hold_data", out_data, 32'h0000_FF00);
      chk("bp_hold_rdy", 32'(in_ready), 32'd0);
      chk("bp_hold_vld", 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 32'(in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("bp_no_ghost", 32'(out_valid), 32'd0);

    // Asynchronous reset during a long shift.
    in_valid = 1'b1;
    in_data  = 32'h0000_0003;
    in_shamt = 5'd20;
    in_mode  = 2'b00;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_vld", 32'(out_valid), 32'd0);
    chk("abort_data", out_data, 32'h0);
    chk("abort_rdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_no_res", 32'(out_valid), 32'd0);
    run_op(32'h1, 5'd1, 2'b00, lat, res);
    chk("post_rst_data", res, 32'h2);
    chk("post_rst_lat", 32'(lat), 32'd2);
    @(negedge clk);

    run_op(32'h1, 5'd1, 2'b11, lat, res);
`ifdef SHIFTER_ROTATE_EN
    chk("ror1_data", res, 32'h8000_0000);
    chk("ror1_lat", 32'(lat), 32'd2);
`else
    chk("ror1_data", res, 32'h1);
    chk("ror1_lat", 32'(lat), 32'd1);
`endif
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/iterative_shifter.md
# iterative_shifter

Multi-cycle, parametrised shifter that generalises the fixed 2-place left shift used in jump-target formation. It supports variable shift amounts and left, logical-right and arithmetic-right modes. It shifts by at most STEP bits per cycle, so a single small step shifter replaces a full barrel shifter in the multi-cycle datapath. Operands arrive and results leave on valid/ready handshakes; the block sits between the ALU-operand mux and the writeback mux.

## Interface
- WIDTH, 32: data width in bits; must be ≥ 2.
- SHAMT_W, $clog2(WIDTH): shift-amount width.
- STEP, 4: maximum bits shifted per cycle; power of two, 1 ≤ STEP ≤ WIDTH.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand request.
- in_ready  output  1  block idle and able to accept an operand.
- in_data  input  WIDTH  operand.
- in_shamt  input  SHAMT_W  shift amount, 0..WIDTH-1.
- in_mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR (see Configuration).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  result.

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid && in_ready, capture in_data, in_shamt into the remaining count, and in_mode. Next state is SHIFT if in_shamt≠0, otherwise DONE.
  - SHIFT: each cycle, shift the held data by k = min(STEP, remaining) and set remaining -= k. Move to DONE in the cycle where remaining becomes 0.
  - DONE: out_valid=1 and out_data holds the result. On out_ready, return to IDLE.
- Shift fill rules:
  - SLL: zero fill from the LSB side.
  - SRL: zero fill from the MSB side.
  - SRA: fill with the captured bit WIDTH-1.
  - ROR: rotate right.
- Inputs are sampled only on the accept edge. Changes on in_* at any other time have no effect.
- No overlap between operations. in_ready is 0 in SHIFT and DONE, including the cycle in which out_ready completes the result handshake. The next accept happens at the earliest one cycle after the result handshake.
- out_data is registered and stays stable throughout DONE.

## Timing
- Accept edge is cycle 0. out_valid rises at cycle ceil(in_shamt/STEP)+1.
  - in_shamt = 0: 1 cycle.
  - WIDTH=32, STEP=4, in_shamt=31: 9 cycles.
- Throughput is one operation per (latency + 1) cycles when out_ready is held high.
- Reset values: in_ready=1, out_valid=0, out_data=0, state IDLE, remaining count 0.
- Reset asserted in any state aborts the operation immediately and asynchronously. No result is produced for the aborted operand.

## Configuration
- SHIFTER_ROTATE_EN defined: mode 11 performs rotate-right using the same STEP-per-cycle iteration.
- SHIFTER_ROTATE_EN undefined:
  - Mode 11 is reserved.
  - The operand is accepted, remaining is forced to 0, and DONE returns in_data unchanged at cycle 1.
  - No rotate logic is synthesised.

## Structure
- Package shifter_pkg holds:
  - shift_mode_e enum: SHIFT_SLL=2'b00, SHIFT_SRL=2'b01, SHIFT_SRA=2'b10, SHIFT_ROR=2'b11.
  - FSM state enum: ST_IDLE, ST_SHIFT, ST_DONE.
- Sub-module shift_step is purely combinational: data, amount 0..STEP, and mode in; shifted data out. It is instantiated once.
- The top level holds the FSM, data register, remaining counter and handshakes.

## Test plan
All scenarios use WIDTH=32 and STEP=4.
- SLL 0x0000_0001, shamt 2, out_ready=1 → out_data 0x0000_0004, out_valid at cycle 2, in_ready high again at cycle 3.
- SRA 0x8000_0000, shamt 31 → 0xFFFF_FFFF at cycle 9. SRL of the same operand and shamt → 0x0000_0001 at cycle 9.
- SRL 0xF000_0000, shamt 0 → 0xF000_0000 at cycle 1. Back-to-back operands with out_ready=1 are accepted every 2 cycles.
- Backpressure: SLL 0x0000_00FF, shamt 8; hold out_ready=0 for 5 cycles → out_data 0x0000_FF00 stays stable and in_ready stays 0. Pulses on in_valid during this time are ignored, and their operands are never processed.
- Reset mid-operation: assert rst_n low at cycle 3 of a shamt-20 SLL → out_valid=0, out_data=0, in_ready=1 immediately. A fresh shamt-1 SLL of 0x1 after release → 0x2 at cycle 2.
- Mode 11, ROR 0x0000_0001, shamt 1:
  - With SHIFTER_ROTATE_EN: 0x8000_0000 at cycle 2.
  - Without it: 0x0000_0001 at cycle 1.
